// File: rtl/mc_decoder_pkg.sv
// Shared types for the multicycle control path: FSM states, mux select codes and opcodes.
// state_ctl() maps a state to its Moore outputs, which the decoder registers.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       next_pc;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } ctl_t;

  function automatic ctl_t state_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_MEMADR: c.alu_src_b = SRCB_IMM;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.reg_w      = 1'b1;
        c.result_src = RES_RDATA;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECR:  c.alu_op = 1'b1;
      S_EXECI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      S_ALUWB:  c.reg_w = 1'b1;
      S_BRANCH: begin
        c.pcs        = 1'b1;
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_decoder_if.sv
// Instruction fields in, raw control enables and datapath selects out.
// master = datapath/instruction register side, slave = decoder.
interface mc_decoder_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic [1:0] flag_w;
  logic       no_write;
  logic       next_pc;
  logic       ir_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] alu_control;
  logic [1:0] imm_src;
  logic [1:0] reg_src;

  modport master (
    output op, funct, rd,
    input  pcs, reg_w, mem_w, flag_w, no_write, next_pc, ir_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src
  );

  modport slave (
    input  op, funct, rd,
    output pcs, reg_w, mem_w, flag_w, no_write, next_pc, ir_write, adr_src,
           alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src
  );
endinterface

// File: rtl/mc_decoder_alu_dec.sv
// Combinational ALU decode: cmd/S/alu_op -> alu_control, flag_w, no_write.
// no_write ignores alu_op so it stays valid through the writeback state.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic       i_alu_op,
  input  logic       i_is_dp,
  input  logic [3:0] i_cmd,
  input  logic       i_s,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w,
  output logic       o_no_write
);

  logic [1:0] w_ctrl;
  logic       w_known;
  logic       w_arith;

  always_comb begin
    w_ctrl  = ALU_ADD;
    w_known = 1'b1;
    w_arith = 1'b0;
    case (i_cmd)
      CMD_ADD: begin w_ctrl = ALU_ADD; w_arith = 1'b1; end
      CMD_SUB: begin w_ctrl = ALU_SUB; w_arith = 1'b1; end
      CMD_CMP: begin w_ctrl = ALU_SUB; w_arith = 1'b1; end
      CMD_AND: w_ctrl = ALU_AND;
      CMD_ORR: w_ctrl = ALU_ORR;
      default: w_known = 1'b0;
    endcase
  end

  // Unsupported commands degrade to a flag-less, write-suppressed ADD.
  assign o_alu_control = i_alu_op ? w_ctrl : ALU_ADD;
  assign o_flag_w      = (i_alu_op && i_s && w_known) ? {1'b1, w_arith} : 2'b00;
  assign o_no_write    = i_is_dp && ((i_cmd == CMD_CMP) || !w_known);

endmodule

// File: rtl/mc_decoder.sv
// Multicycle Moore control FSM: fetch/decode/execute/memory/writeback sequencing.
// State-based enables are registered; only ALU decode, imm/reg src and the rd=PC pcs term are combinational.
module mc_decoder
  import mc_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mc_decoder_if.slave  dec
);

  state_t r_state;
  state_t w_next_state;
  ctl_t   r_ctl;
  logic   w_wb_pc;

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (dec.op)
          OP_MEM:  w_next_state = S_MEMADR;
          OP_DP:   w_next_state = dec.funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: w_next_state = dec.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next_state = S_MEMWB;
      S_EXECR:  w_next_state = S_ALUWB;
      S_EXECI:  w_next_state = S_ALUWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ctl   <= state_ctl(S_FETCH);
    end else begin
      r_state <= w_next_state;
      r_ctl   <= state_ctl(w_next_state);
    end
  end

  assign w_wb_pc = ((r_state == S_MEMWB) || (r_state == S_ALUWB)) && (dec.rd == 4'hF);

  assign dec.pcs        = r_ctl.pcs | w_wb_pc;
  assign dec.reg_w      = r_ctl.reg_w;
  assign dec.mem_w      = r_ctl.mem_w;
  assign dec.next_pc    = r_ctl.next_pc;
  assign dec.ir_write   = r_ctl.ir_write;
  assign dec.adr_src    = r_ctl.adr_src;
  assign dec.alu_src_a  = r_ctl.alu_src_a;
  assign dec.alu_src_b  = r_ctl.alu_src_b;
  assign dec.result_src = r_ctl.result_src;
  assign dec.imm_src    = dec.op;
  assign dec.reg_src    = {dec.op == OP_MEM, dec.op == OP_BR};

  alu_dec u_alu_dec (
    .i_alu_op      (r_ctl.alu_op),
    .i_is_dp       (dec.op == OP_DP),
    .i_cmd         (dec.funct[4:1]),
    .i_s           (dec.funct[0]),
    .o_alu_control (dec.alu_control),
    .o_flag_w      (dec.flag_w),
    .o_no_write    (dec.no_write)
  );

endmodule
